// File: rtl/fifo_stream_adapter_pkg.sv
// rtl/fifo_stream_adapter_pkg.sv - shared types and helpers for fifo_stream_adapter
package fifo_stream_adapter_pkg;

  // Output buffer depth; pointers are one bit and wrap modulo this depth.
  localparam int unsigned BUF_DEPTH = 2;

  // Buffer occupancy, 0..BUF_DEPTH.
  typedef logic [1:0] occ_t;

  // True when a read issued this cycle is guaranteed a free slot on landing:
  // words already held plus the one in flight, minus the word leaving now,
  // must stay below the buffer depth.
  function automatic logic slot_free(input occ_t occ, input logic inflight, input logic pop);
    logic [2:0] committed;
    logic [2:0] limit;
    committed = {1'b0, occ} + {2'b00, inflight};
    limit     = 3'(BUF_DEPTH) + {2'b00, pop};
    return committed < limit;
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_skid_buf.sv
// rtl/fifo_stream_adapter_skid_buf.sv - two-entry register buffer holding stream words
module stream_skid_buf
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic                  wr_ptr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_ptr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];

  // Storage cells; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  // Head word comes straight from flops, never from the upstream data bus.
  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/fifo_stream_adapter.sv
// rtl/fifo_stream_adapter.sv - 1-cycle-latency FIFO pull port to valid/ready stream adapter
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  beat_count
);

  localparam logic [CNT_WIDTH-1:0] BEAT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] BEAT_ONE = CNT_WIDTH'(1);

  occ_t                 occ_q, occ_d;
  logic                 inflight_q, inflight_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic                 armed_q;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic                 pop;
  logic                 capture;

  assign m_valid    = (occ_q != 2'd0);
  assign pop        = m_valid & m_ready;
  // Registered read data is valid exactly one cycle after the accepted read.
  assign capture    = inflight_q;
  // Reads are held off for the first cycle out of reset via armed_q, and only
  // issued when the word is certain to have a slot when it arrives.
  assign fifo_r_en  = armed_q & ~fifo_empty & slot_free(occ_q, inflight_q, pop);
  assign beat_count = beat_q;

  // Next-state for occupancy, pointers, in-flight flag and saturating beat counter.
  always_comb begin
    occ_d      = occ_q;
    inflight_d = fifo_r_en;
    wr_ptr_d   = wr_ptr_q ^ capture;
    rd_ptr_d   = rd_ptr_q ^ pop;
    beat_d     = beat_q;
    case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (pop && (beat_q != BEAT_MAX)) begin
      beat_d = beat_q + BEAT_ONE;
    end
  end

  // State registers; reset drops any read in flight so its data is never captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      armed_q    <= 1'b0;
      beat_q     <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      armed_q    <= 1'b1;
      beat_q     <= beat_d;
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (capture),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (fifo_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (m_data)
  );

  // The read gating must make a capture into a full buffer unreachable.
  a_no_capture_when_full: assert property (@(posedge clk) disable iff (rst)
    !(capture && (occ_q == 2'd2)));

  // Never strobe the upstream FIFO while it reports empty.
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
    !(fifo_r_en && fifo_empty));

endmodule

// File: doc/fifo_stream_adapter.md
FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of every data word.
REQ-002 Parameter CNT_WIDTH, default 16, width of the beat counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 fifo_empty  input  1  upstream synchronous FIFO empty flag.
REQ-006 fifo_r_en  output  1  read strobe to upstream FIFO.
REQ-007 fifo_data  input  DATA_WIDTH  upstream registered read data, valid exactly 1 cycle after an accepted read.
REQ-008 m_valid  output  1  downstream stream word valid.
REQ-009 m_ready  input  1  downstream accepts word.
REQ-010 m_data  output  DATA_WIDTH  downstream stream word.
REQ-011 beat_count  output  CNT_WIDTH  number of words delivered downstream, saturating.

Function
REQ-012 The block SHALL convert the FIFO's 1-cycle-latency pull interface into a valid/ready stream with no word lost, duplicated or reordered.
REQ-013 Accepted read: fifo_r_en=1 while fifo_empty=0; the block SHALL never assert fifo_r_en while fifo_empty=1.
REQ-014 The block SHALL hold a 2-entry output buffer (occ 0..2) and a 1-bit in-flight flag set on an accepted read, cleared the next cycle.
REQ-015 On the cycle after an accepted read, fifo_data SHALL be captured into the buffer tail.
REQ-016 fifo_r_en SHALL be asserted iff fifo_empty=0 and (occ + inflight - pop) < 2, where pop = m_valid & m_ready in the same cycle.
REQ-017 Sustained throughput SHALL be 1 word/cycle when the FIFO stays non-empty and m_ready=1 continuously.
REQ-018 m_valid SHALL equal (occ != 0); m_data SHALL be the buffer head, registered, no combinational path from fifo_data.
REQ-019 m_valid and m_data SHALL stay stable while m_valid=1 and m_ready=0.
REQ-020 Simultaneous capture and pop: occ unchanged, head advances, captured word goes to tail in order.
REQ-021 Capture with occ=2 SHALL be impossible by construction; an assertion SHALL flag it.
REQ-022 First-word latency: fifo_empty falls at cycle N -> fifo_r_en at N -> m_valid at N+2.
REQ-023 beat_count SHALL increment by 1 per pop and SHALL saturate at 2^CNT_WIDTH-1, not wrap.
REQ-024 m_ready toggling with m_valid=0 SHALL have no effect.

Reset
REQ-025 While rst=1: fifo_r_en=0, m_valid=0, m_data=0, beat_count=0, occ=0, inflight=0, asynchronously.
REQ-026 A read in flight when rst asserts SHALL be discarded; its data SHALL NOT appear after reset.
REQ-027 fifo_r_en SHALL stay 0 in the first cycle after rst deasserts.

Structure
REQ-028 No shared package required; DATA_WIDTH and CNT_WIDTH are module parameters only.
REQ-029 The 2-entry buffer MAY be a sub-module named stream_skid_buf; pointer and occupancy logic stays in fifo_stream_adapter.
REQ-030 Buffer pointers SHALL be 1 bit and wrap modulo 2.

Verification
REQ-031 Reset then FIFO holds 0x11,0x22,0x33, m_ready=1 -> m_data 0x11,0x22,0x33 on 3 consecutive cycles starting 2 cycles after first fifo_r_en; beat_count=3.
REQ-032 FIFO holds 0xA0..0xA7, m_ready=0 -> exactly 2 reads, m_valid=1, m_data=0xA0 stable; fifo_r_en=0 thereafter.
REQ-033 Same as REQ-032, then m_ready=1 -> remaining 0xA1..0xA7 delivered in order at 1/cycle, no duplicates.
REQ-034 Random m_ready (50%), 1000 random words -> output equals input sequence; fifo_r_en never high with fifo_empty=1.
REQ-035 Assert rst the cycle after fifo_r_en with data 0x5A pending -> all outputs 0 immediately; 0x5A never appears on m_data.
REQ-036 CNT_WIDTH=4, 20 words delivered -> beat_count reads 15 and holds.
